pim_peri_seq_ctrl: RTL and testbench

//  Parametrised eFlash PIM peripheral sequencer. It replaces static register-driven row/column controls with an

---
 rtl/pim_peri_seq_ctrl.sv | 206 ++++++++++++++++++++
 tb/tb_pim_peri_seq_ctrl.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/pim_peri_seq_ctrl.sv
// eFlash PIM peripheral sequencer: MMIO-started precharge/wordline/ADC/capture/discharge
// phase FSM driving NUM_BANKS macros, with a readback buffer of the last captured bitlines.
module pim_peri_seq_ctrl #(
   parameter logic [31:0] BASE_ADDR = 32'h4000_0000,
   parameter int NUM_ROWS  = 128,
   parameter int COL_BITS  = 1024,
   parameter int NUM_BANKS = 2,
   parameter int PRE_W     = 128,
   parameter int T_PRE     = 4,
   parameter int T_WL      = 8,
   parameter int T_ADC     = 6,
   parameter int T_DISC    = 3,
   parameter int T_PGM     = 32,
   localparam int BW       = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1
) (
   input  logic                          clk_i,
   input  logic                          rst_i,
   input  logic [31:0]                   address_i,
   input  logic [31:0]                   data_i,
   input  logic                          we_i,
   input  logic                          re_i,
   output logic [31:0]                   data_o,
   input  logic [NUM_BANKS*COL_BITS-1:0] eflash_out_i,
   output logic [1:0]                    mode_o,
   output logic [NUM_ROWS-1:0]           wl_sel_o,
   output logic [NUM_ROWS-1:0]           vpass_en_o,
   output logic [BW-1:0]                 bsel_o,
   output logic [NUM_BANKS-1:0]          adc_en_o,
   output logic [PRE_W-1:0]              precb_o,
   output logic [PRE_W-1:0]              disc_o,
   output logic                          busy_o
);

   localparam int RW   = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;
   // CTRL bank field is one bit wider than bsel so out-of-range banks are detectable
   localparam int BFW  = BW + 1;
   localparam int NW   = COL_BITS / 32;
   localparam int KW   = (NW > 1) ? $clog2(NW) : 1;
   localparam int TM1  = (T_PRE > T_WL) ? T_PRE : T_WL;
   localparam int TM2  = (T_ADC > T_DISC) ? T_ADC : T_DISC;
   localparam int TM3  = (TM1 > TM2) ? TM1 : TM2;
   localparam int TMAX = (TM3 > T_PGM) ? TM3 : T_PGM;
   localparam int CW   = (TMAX > 1) ? $clog2(TMAX) : 1;
   localparam logic [BFW-1:0] NB   = BFW'(NUM_BANKS);
   localparam logic [29:0]    NW30 = 30'(NW);

   typedef enum logic [2:0] {S_IDLE, S_PRE, S_WL, S_ADC, S_CAPT, S_DISC} state_t;

   state_t                       state_q, state_d;
   logic [CW-1:0]                cnt_q, cnt_d;
   logic [1:0]                   mode_q, mode_d;
   logic [BFW-1:0]               bank_q, bank_d;
   logic [RW-1:0]                row_q, row_d;
   logic                         done_q, done_d;
   logic                         err_q, err_d;
   logic [NW-1:0][31:0]          capture_q, capture_d;
   logic [31:0]                  data_q, data_d;

   logic [NUM_BANKS-1:0][COL_BITS-1:0] bank_view;
   logic [31:0]                  off, res_off;
   logic                         hit_ctrl, hit_row, hit_stat, hit_res;
   logic [KW-1:0]                res_idx;
   logic                         busy, pgm;
   logic [BFW-1:0]               wr_bank;
   logic [NUM_ROWS-1:0]          wl_onehot;

   assign bank_view = eflash_out_i;
   assign busy      = (state_q != S_IDLE);
   assign pgm       = mode_q[0] ^ mode_q[1];
   assign wr_bank   = data_i[3 +: BFW];

   assign off      = address_i - BASE_ADDR;
   assign res_off  = off - 32'h10;
   assign hit_ctrl = (off == 32'h0);
   assign hit_row  = (off == 32'h4);
   assign hit_stat = (off == 32'h8);
   assign hit_res  = (off[1:0] == 2'b00) && (off >= 32'h10) && (res_off[31:2] < NW30);
   assign res_idx  = res_off[KW+1:2];

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      mode_d    = mode_q;
      bank_d    = bank_q;
      row_d     = row_q;
      done_d    = done_q;
      err_d     = err_q;
      capture_d = capture_q;
      data_d    = data_q;

      if (we_i && hit_stat) begin
         if (data_i[1]) done_d = 1'b0;
         if (data_i[2]) err_d  = 1'b0;
      end

      // Each phase loads duration-1; the cycle that sees zero moves on
      if (busy && cnt_q != '0) begin
         cnt_d = cnt_q - 1'b1;
      end else begin
         unique case (state_q)
            S_PRE: begin
               state_d = S_WL;
               cnt_d   = pgm ? CW'(T_PGM - 1) : CW'(T_WL - 1);
            end
            S_WL: begin
               state_d = pgm ? S_DISC : S_ADC;
               cnt_d   = pgm ? CW'(T_DISC - 1) : CW'(T_ADC - 1);
            end
            S_ADC: begin
               state_d = S_CAPT;
               cnt_d   = '0;
            end
            S_CAPT: begin
               capture_d = bank_view[bank_q[BW-1:0]];
               state_d   = S_DISC;
               cnt_d     = CW'(T_DISC - 1);
            end
            S_DISC: begin
               state_d = S_IDLE;
               done_d  = 1'b1;
            end
            default: ;
         endcase
      end

      if (we_i && (hit_ctrl || hit_row)) begin
         if (busy) begin
            err_d = 1'b1;
         end else if (hit_row) begin
            row_d = data_i[RW-1:0];
         end else begin
            mode_d = data_i[2:1];
            bank_d = wr_bank;
            if (data_i[0]) begin
               if (wr_bank >= NB) begin
                  err_d = 1'b1;
               end else begin
                  state_d = S_PRE;
                  cnt_d   = CW'(T_PRE - 1);
               end
            end
         end
      end

      if (re_i) begin
         data_d = '0;
         if (hit_ctrl) begin
            data_d[2:1]       = mode_q;
            data_d[3 +: BFW]  = bank_q;
         end else if (hit_row) begin
            data_d[RW-1:0] = row_q;
         end else if (hit_stat) begin
            data_d[2:0] = {err_q, done_q, busy};
         end else if (hit_res) begin
            data_d = capture_q[res_idx];
         end
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         mode_q    <= '0;
         bank_q    <= '0;
         row_q     <= '0;
         done_q    <= 1'b0;
         err_q     <= 1'b0;
         capture_q <= '0;
         data_q    <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         mode_q    <= mode_d;
         bank_q    <= bank_d;
         row_q     <= row_d;
         done_q    <= done_d;
         err_q     <= err_d;
         capture_q <= capture_d;
         data_q    <= data_d;
      end
   end

   always_comb begin
      wl_onehot = '0;
      wl_onehot[row_q] = 1'b1;
      mode_o     = busy ? mode_q : 2'b00;
      bsel_o     = busy ? bank_q[BW-1:0] : '0;
      wl_sel_o   = '0;
      vpass_en_o = '0;
      adc_en_o   = '0;
      precb_o    = '1;
      disc_o     = '0;
      if (state_q == S_WL || state_q == S_ADC || state_q == S_CAPT) begin
         wl_sel_o   = wl_onehot;
         vpass_en_o = ~wl_onehot;
      end
      if (state_q == S_ADC || state_q == S_CAPT) adc_en_o[bank_q[BW-1:0]] = 1'b1;
      if (state_q == S_PRE)  precb_o = '0;
      if (state_q == S_DISC) disc_o  = '1;
   end

   assign busy_o = busy;
   assign data_o = data_q;

endmodule

// File: tb/tb_pim_peri_seq_ctrl.sv
// Bench for pim_peri_seq_ctrl: table-driven phase-count vectors, randomized sequences against
// a per-phase duration model, and hand-written collision / bad-bank / back-to-back / reset cases.
module tb_pim_peri_seq_ctrl;
   localparam logic [31:0] BASE = 32'h4000_0000;
   localparam int NR = 128, CB = 1024, NBK = 2, PW = 128, NWD = CB / 32;
   localparam int TP = 4, TW = 8, TA = 6, TD = 3, TG = 32;

   logic              clk = 1'b0, rst_i = 1'b1;
   logic [31:0]       address_i = '0, data_i = '0;
   logic              we_i = 1'b0, re_i = 1'b0;
   logic [31:0]       data_o;
   logic [NBK*CB-1:0] eflash_out_i = '0;
   logic [1:0]        mode_o;
   logic [NR-1:0]     wl_sel_o, vpass_en_o;
   logic [0:0]        bsel_o;
   logic [NBK-1:0]    adc_en_o;
   logic [PW-1:0]     precb_o, disc_o;
   logic              busy_o;

   pim_peri_seq_ctrl dut (
      .clk_i(clk), .rst_i(rst_i), .address_i(address_i), .data_i(data_i), .we_i(we_i), .re_i(re_i),
      .data_o(data_o), .eflash_out_i(eflash_out_i), .mode_o(mode_o), .wl_sel_o(wl_sel_o),
      .vpass_en_o(vpass_en_o), .bsel_o(bsel_o), .adc_en_o(adc_en_o), .precb_o(precb_o),
      .disc_o(disc_o), .busy_o(busy_o)
   );

   always #5 clk = ~clk;

   int nvec = 0, nmis = 0;
   logic [31:0] efw [NBK][NWD];
   logic [31:0] capm [NWD];

   typedef struct {
      logic [1:0]  mode;
      int          bank, row;
      logic [31:0] pat0, pat1;
      int          e_busy, e_pre, e_wl, e_adc, e_disc;
      logic [31:0] e_res0;
   } vec_t;
   vec_t vt [4];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      nvec++;
      if (act !== exp) begin
         nmis++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   task automatic load_flash();
      for (int b = 0; b < NBK; b++)
         for (int k = 0; k < NWD; k++) eflash_out_i[b*CB + 32*k +: 32] = efw[b][k];
   endtask

   task automatic bus_wr(input logic [31:0] off, input logic [31:0] d);
      address_i = BASE + off; data_i = d; we_i = 1'b1;
      @(negedge clk);
      we_i = 1'b0;
   endtask

   task automatic bus_rd(input logic [31:0] off, output logic [31:0] d);
      address_i = BASE + off; re_i = 1'b1;
      @(negedge clk);
      re_i = 1'b0;
      d = data_o;
   endtask

   // Watch one sequence cycle by cycle; optionally inject writes that must be rejected
   task automatic run_seq(input logic [1:0] mode, input int bank, input int row, input bit inject,
                          output int nb, output int npre, output int nwl, output int nadc,
                          output int ndisc, output int nbad);
      logic [NR-1:0] oh;
      int cyc;
      oh = '0; oh[row] = 1'b1;
      nb = 0; npre = 0; nwl = 0; nadc = 0; ndisc = 0; nbad = 0; cyc = 0;
      bus_wr(32'h4, row);
      bus_wr(32'h0, (bank << 3) | (mode << 1) | 1);
      while (busy_o && cyc < 200) begin
         nb++;
         if (precb_o == '0) npre++;
         if (wl_sel_o == oh && vpass_en_o == ~oh) nwl++;
         if (adc_en_o == NBK'(1 << bank)) nadc++;
         if (disc_o == '1) ndisc++;
         if (mode_o != mode || bsel_o != 1'(bank)) nbad++;
         we_i = 1'b0;
         if (inject && cyc == 5) begin address_i = BASE; data_i = 32'h1; we_i = 1'b1; end
         if (inject && cyc == 8) begin address_i = BASE + 4; data_i = row ^ 1; we_i = 1'b1; end
         cyc++;
         @(negedge clk);
      end
      we_i = 1'b0;
      if (cyc >= 200) chk("seq_timeout", 1, 0);
   endtask

   function automatic bit is_pgm(input logic [1:0] m);
      return (m == 2'b01) || (m == 2'b10);
   endfunction

   initial begin
      int nb, npre, nwl, nadc, ndisc, nbad, w;
      logic [31:0] rd, hold;
      logic [1:0] m;
      int bk, rw, k;

      vt[0] = '{2'b00, 0,   5, 32'hA5A5_A5A5, 32'h5A5A_5A5A, 22, 4, 15, 7, 3, 32'hA5A5_A5A5};
      vt[1] = '{2'b01, 1, 127, 32'hA5A5_A5A5, 32'h5A5A_5A5A, 39, 4, 32, 0, 3, 32'hA5A5_A5A5};
      vt[2] = '{2'b11, 1,   0, 32'h1111_2222, 32'h3C3C_0F0F, 22, 4, 15, 7, 3, 32'h3C3C_0F0F};
      vt[3] = '{2'b10, 0,  64, 32'hDEAD_BEEF, 32'h0BAD_F00D, 39, 4, 32, 0, 3, 32'h3C3C_0F0F};
      for (int i = 0; i < NWD; i++) capm[i] = '0;

      // reset state
      @(negedge clk); @(negedge clk);
      chk("rst_busy", busy_o, 0);
      chk("rst_precb", precb_o == '1, 1);
      chk("rst_misc", {mode_o, bsel_o, |wl_sel_o, |vpass_en_o, |adc_en_o, |disc_o}, 0);
      chk("rst_data", data_o, 0);
      rst_i = 1'b0;
      @(negedge clk);
      bus_rd(32'h8, rd); chk("rst_status", rd, 0);

      // table vectors
      for (int i = 0; i < 4; i++) begin
         for (int k2 = 0; k2 < NWD; k2++) begin efw[0][k2] = vt[i].pat0; efw[1][k2] = vt[i].pat1; end
         load_flash();
         run_seq(vt[i].mode, vt[i].bank, vt[i].row, 1'b0, nb, npre, nwl, nadc, ndisc, nbad);
         chk($sformatf("v%0d_busy", i), nb, vt[i].e_busy);
         chk($sformatf("v%0d_pre", i), npre, vt[i].e_pre);
         chk($sformatf("v%0d_wl", i), nwl, vt[i].e_wl);
         chk($sformatf("v%0d_adc", i), nadc, vt[i].e_adc);
         chk($sformatf("v%0d_disc", i), ndisc, vt[i].e_disc);
         chk($sformatf("v%0d_modebank", i), nbad, 0);
         bus_rd(32'h8, rd); chk($sformatf("v%0d_status", i), rd, 32'h2);
         bus_rd(32'h10, rd); chk($sformatf("v%0d_res0", i), rd, vt[i].e_res0);
         bus_wr(32'h8, 32'h2);
         if (!is_pgm(vt[i].mode)) for (int k2 = 0; k2 < NWD; k2++) capm[k2] = efw[vt[i].bank][k2];
      end
      bus_rd(32'h8, rd); chk("w1c_done", rd, 0);
      bus_rd(32'h8C, rd); chk("res31", rd, capm[31]);
      hold = rd;
      repeat (3) @(negedge clk);
      chk("data_hold", data_o, hold);

      // randomized sequences against the duration/capture model
      for (int i = 0; i < 8; i++) begin
         m = 2'($urandom_range(0, 3)); bk = $urandom_range(0, 1); rw = $urandom_range(0, NR - 1);
         for (int b = 0; b < NBK; b++) for (int k2 = 0; k2 < NWD; k2++) efw[b][k2] = $urandom;
         load_flash();
         run_seq(m, bk, rw, 1'b0, nb, npre, nwl, nadc, ndisc, nbad);
         chk($sformatf("r%0d_busy", i), nb, TP + (is_pgm(m) ? TG : TW + TA + 1) + TD);
         chk($sformatf("r%0d_wl", i), nwl, is_pgm(m) ? TG : TW + TA + 1);
         chk($sformatf("r%0d_adc", i), nadc, is_pgm(m) ? 0 : TA + 1);
         chk($sformatf("r%0d_pd", i), npre + ndisc + nbad, TP + TD);
         if (!is_pgm(m)) for (int k2 = 0; k2 < NWD; k2++) capm[k2] = efw[bk][k2];
         for (int j = 0; j < 2; j++) begin
            k = $urandom_range(0, NWD - 1);
            bus_rd(32'h10 + 4 * k, rd); chk($sformatf("r%0d_res%0d", i, k), rd, capm[k]);
         end
         bus_wr(32'h8, 32'h2);
      end

      // collision: start and ROW write during busy are ignored and flag err
      run_seq(2'b00, 1, 9, 1'b1, nb, npre, nwl, nadc, ndisc, nbad);
      chk("col_busy", nb, 22);
      chk("col_wl", nwl, 15);
      bus_rd(32'h8, rd); chk("col_status", rd, 32'h6);
      bus_wr(32'h8, 32'h4);
      bus_rd(32'h8, rd); chk("col_w1c_err", rd, 32'h2);
      bus_rd(32'h4, rd); chk("col_row", rd, 9);
      bus_wr(32'h8, 32'h2);

      // bad bank
      bus_wr(32'h0, 32'h19);
      chk("bad_nobusy", busy_o, 0);
      @(negedge clk);
      chk("bad_nobusy2", busy_o, 0);
      bus_rd(32'h8, rd); chk("bad_err", rd, 32'h4);
      bus_wr(32'h8, 32'h4);

      // back-to-back: start on the first idle cycle
      run_seq(2'b00, 0, 3, 1'b0, nb, npre, nwl, nadc, ndisc, nbad);
      chk("b2b_first", nb, 22);
      bus_wr(32'h0, 32'h1);
      chk("b2b_busy", busy_o, 1);
      bus_rd(32'h8, rd); chk("b2b_status", rd, 32'h3);
      w = 0;
      while (busy_o && w < 100) begin @(negedge clk); w++; end
      chk("b2b_end", busy_o, 0);
      bus_rd(32'h8, rd); chk("b2b_done", rd, 32'h2);
      bus_rd(32'h90, rd); chk("res_oor", rd, 0);
      bus_rd(32'h14, rd); chk("b2b_res1", rd, efw[0][1]);
      bus_wr(32'h8, 32'h2);

      // reset in the middle of ADC
      bus_wr(32'h0, 32'h1);
      w = 0;
      while (adc_en_o == '0 && w < 50) begin @(negedge clk); w++; end
      chk("adc_seen", adc_en_o, 2'b01);
      #1 rst_i = 1'b1;
      #1;
      chk("mrst_busy", busy_o, 0);
      chk("mrst_precb", precb_o == '1, 1);
      chk("mrst_misc", {mode_o, bsel_o, |wl_sel_o, |vpass_en_o, |adc_en_o, |disc_o}, 0);
      chk("mrst_data", data_o, 0);
      @(negedge clk);
      rst_i = 1'b0;
      @(negedge clk);
      bus_rd(32'h8, rd); chk("mrst_status", rd, 0);
      bus_rd(32'h10, rd); chk("mrst_res0", rd, 0);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: got running want finished");
      $fatal(1);
   end
endmodule
